// File: rtl/seg7_scan_4digit_if.sv
// Display-side bundle for the 4-digit scanner: refresh input, digit data and
// the multiplexed anode/segment drive.
interface seg7_scan_4digit_if;
    logic        refresh_in;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;

    modport master (
        output refresh_in, value, dp_in, blank_lz,
        input  an, seg, dp, digit_idx
    );

    modport slave (
        input  refresh_in, value, dp_in, blank_lz,
        output an, seg, dp, digit_idx
    );
endinterface

// File: rtl/seg7_scan_4digit.sv
// Common-anode 4-digit 7-segment scanner. A synchronised 500 Hz refresh edge
// advances one digit per tick, with an all-off blanking gap between digits.
module seg7_scan_4digit #(
    parameter int BLANK_CYCLES = 64
) (
    input  logic              clk_in,
    input  logic              rst,
    seg7_scan_4digit_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every more-significant nibble are zero.
    function automatic logic lz_blank(input logic [15:0] v, input logic lz,
                                      input logic [1:0] idx);
        logic z;
        case (idx)
            2'd3:    z = (v[15:12] == 4'h0);
            2'd2:    z = (v[15:8]  == 8'h00);
            2'd1:    z = (v[15:4]  == 12'h000);
            default: z = 1'b0;
        endcase
        return lz & z;
    endfunction

    logic        sync_p0, sync_p1, sync_p2;
    logic        tick;
    logic [1:0]  state;
    logic [7:0]  blank_cnt;
    logic [1:0]  digit_idx_r;
    logic [15:0] sh_value;
    logic [3:0]  sh_dp;
    logic        sh_lz;
    logic [3:0]  an_r;
    logic [6:0]  seg_r;
    logic        dp_r;

    logic [1:0]  nxt_idx;
    logic [15:0] src_value;
    logic [3:0]  src_dp;
    logic        src_lz;
    logic [3:0]  nxt_nib;
    logic [6:0]  nxt_seg;

    assign tick = sync_p1 & ~sync_p2;

    // Digit 0 reads the live inputs, since the shadow copy is loaded on that same edge.
    always_comb begin
        nxt_idx = digit_idx_r + 2'd1;
        if (nxt_idx == 2'd0) begin
            src_value = bus.value;
            src_dp    = bus.dp_in;
            src_lz    = bus.blank_lz;
        end else begin
            src_value = sh_value;
            src_dp    = sh_dp;
            src_lz    = sh_lz;
        end
        nxt_nib = src_value[{nxt_idx, 2'b00} +: 4];
        nxt_seg = lz_blank(src_value, src_lz, nxt_idx) ? 7'h7F : hex7(nxt_nib);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_p0     <= 1'b0;
            sync_p1     <= 1'b0;
            sync_p2     <= 1'b0;
            state       <= S_IDLE;
            blank_cnt   <= 8'd0;
            digit_idx_r <= 2'd3;
            sh_value    <= 16'h0000;
            sh_dp       <= 4'h0;
            sh_lz       <= 1'b0;
            an_r        <= 4'b1111;
            seg_r       <= 7'h7F;
            dp_r        <= 1'b1;
        end else begin
            // p0/p1: metastability filter; p2: previous level for edge detect
            sync_p0 <= bus.refresh_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;

            case (state)
                S_IDLE, S_SHOW: begin
                    if (tick) begin
                        state     <= S_BLANK;
                        blank_cnt <= 8'd0;
                        an_r      <= 4'b1111;
                        seg_r     <= 7'h7F;
                        dp_r      <= 1'b1;
                    end
                end
                S_BLANK: begin
                    // Ticks here are ignored: the gap length is fixed.
                    if (blank_cnt == BLANK_LAST) begin
                        state       <= S_SHOW;
                        digit_idx_r <= nxt_idx;
                        an_r        <= ~(4'b0001 << nxt_idx);
                        seg_r       <= nxt_seg;
                        dp_r        <= ~src_dp[nxt_idx];
                        if (nxt_idx == 2'd0) begin
                            sh_value <= bus.value;
                            sh_dp    <= bus.dp_in;
                            sh_lz    <= bus.blank_lz;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.an        = an_r;
    assign bus.seg       = seg_r;
    assign bus.dp        = dp_r;
    assign bus.digit_idx = digit_idx_r;

endmodule

// File: tb/tb_seg7_scan_4digit.sv
// Self-checking bench for seg7_scan_4digit: fixed scan vectors, a randomized
// scan model, dropped-tick and reset corner cases.
module tb_seg7_scan_4digit;

    localparam int BC = 64;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
        logic        b;
        logic [27:0] eseg;   // digit n at [7n+6:7n]
        logic [3:0]  edp;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    vec_t tbl [6];

    seg7_scan_4digit_if dif ();

    seg7_scan_4digit #(.BLANK_CYCLES(BC)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (dif)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: nibble lookup, with leading zeros meaning "v shifted down to this digit is zero".
    function automatic logic [6:0] model_seg(input logic [15:0] v, input logic b, input int n);
        int rest;
        rest = int'(v) >> (4 * n);
        if (b && n > 0 && rest == 0) return 7'h7F;
        return HEX[rest & 15];
    endfunction

    // Raises refresh_in just after a clock edge and counts edges until SHOW.
    task automatic digit_step(input bit glitch, output int show_k, output int blank_n);
        dif.refresh_in = 1'b1;
        show_k  = 0;
        blank_n = 0;
        for (int k = 1; k <= 300 && show_k == 0; k++) begin
            @(posedge clk_in); #1;
            if (glitch && k == 10) dif.refresh_in = 1'b0;
            if (glitch && k == 20) dif.refresh_in = 1'b1;
            if (k >= 3) begin
                if (dif.an == 4'b1111) blank_n++;
                else show_k = k;
            end
        end
        dif.refresh_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
    endtask

    task automatic run_scan(input logic [15:0] v, input logic [3:0] d, input logic b,
                            input logic [27:0] eseg, input logic [3:0] edp,
                            input bit mid, input logic [15:0] mid_v, input int mid_after);
        int sk, bn;
        dif.value = v; dif.dp_in = d; dif.blank_lz = b;
        for (int n = 0; n < 4; n++) begin
            digit_step(1'b0, sk, bn);
            chk("show_latency", sk, 3 + BC);
            chk("blank_len", bn, BC);
            chk("an", {28'd0, dif.an}, {28'd0, ~(4'b0001 << n)});
            chk("seg", {25'd0, dif.seg}, {25'd0, eseg[7*n +: 7]});
            chk("dp", {31'd0, dif.dp}, {31'd0, edp[n]});
            chk("digit_idx", {30'd0, dif.digit_idx}, n);
            if (mid && n == mid_after) begin
                dif.value = mid_v; dif.dp_in = ~d; dif.blank_lz = ~b;
            end
        end
    endtask

    initial begin
        int sk, bn;
        int stable_bad;
        logic [15:0] rv;
        logic [3:0]  rd;
        logic        rb;
        logic [27:0] es;

        tbl[0] = '{16'h12AF, 4'b0100, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011};
        tbl[1] = '{16'h0005, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111};
        tbl[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        tbl[3] = '{16'hF0E0, 4'b1001, 1'b1, {7'h0E, 7'h40, 7'h06, 7'h40}, 4'b0110};
        tbl[4] = '{16'h0120, 4'b0011, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h40}, 4'b1100};
        tbl[5] = '{16'h0005, 4'b1000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b0111};

        dif.refresh_in = 1'b0; dif.value = 16'h0; dif.dp_in = 4'h0; dif.blank_lz = 1'b0;

        // Reset held with refresh toggling: display must stay dark
        for (int i = 0; i < 24; i++) begin
            @(posedge clk_in); #1;
            if (i % 3 == 0) dif.refresh_in = ~dif.refresh_in;
            chk("reset_an", {28'd0, dif.an}, 32'hF);
        end
        chk("reset_seg", {25'd0, dif.seg}, 32'h7F);
        chk("reset_dp", {31'd0, dif.dp}, 32'h1);
        chk("reset_idx", {30'd0, dif.digit_idx}, 32'h3);
        dif.refresh_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("idle_dark", {28'd0, dif.an}, 32'hF);

        for (int t = 0; t < 6; t++)
            run_scan(tbl[t].v, tbl[t].d, tbl[t].b, tbl[t].eseg, tbl[t].edp, 1'b0, 16'h0, 0);

        // Value changes while digit 2 is shown; digit 3 must still come from the old value
        run_scan(16'h1111, 4'b0000, 1'b0, {4{7'h79}}, 4'b1111, 1'b1, 16'h2222, 2);
        run_scan(16'h2222, 4'b0000, 1'b0, {4{7'h24}}, 4'b1111, 1'b0, 16'h0, 0);

        for (int r = 0; r < 10; r++) begin
            rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
            rd = 4'($urandom);
            rb = 1'($urandom);
            for (int n = 0; n < 4; n++) es[7*n +: 7] = model_seg(rv, rb, n);
            run_scan(rv, rd, rb, es, ~rd, 1'b1, 16'($urandom), $urandom_range(0, 2));
        end

        // Second refresh rise while blanking must be dropped
        dif.value = 16'h12AF; dif.dp_in = 4'b0000; dif.blank_lz = 1'b0;
        digit_step(1'b1, sk, bn);
        chk("drop_show_latency", sk, 3 + BC);
        chk("drop_blank_len", bn, BC);
        chk("drop_idx", {30'd0, dif.digit_idx}, 32'h0);
        stable_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in); #1;
            if (dif.an != 4'b1110 || dif.digit_idx != 2'd0) stable_bad++;
        end
        chk("drop_no_rescan", stable_bad, 0);

        // Reset asserted 30 cycles into BLANK
        dif.refresh_in = 1'b1;
        repeat (33) @(posedge clk_in);
        #1 rst = 1'b1;
        #1;
        chk("midrst_an", {28'd0, dif.an}, 32'hF);
        chk("midrst_seg", {25'd0, dif.seg}, 32'h7F);
        chk("midrst_dp", {31'd0, dif.dp}, 32'h1);
        chk("midrst_idx", {30'd0, dif.digit_idx}, 32'h3);
        @(posedge clk_in); #1;
        dif.refresh_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1 rst = 1'b0;
        repeat (80) @(posedge clk_in);
        #1;
        chk("midrst_stays_dark", {28'd0, dif.an}, 32'hF);
        dif.value = 16'h0007; dif.dp_in = 4'b0001; dif.blank_lz = 1'b0;
        digit_step(1'b0, sk, bn);
        chk("midrst_show_latency", sk, 3 + BC);
        chk("midrst_blank_len", bn, BC);
        chk("midrst_first_an", {28'd0, dif.an}, 32'hE);
        chk("midrst_first_seg", {25'd0, dif.seg}, 32'h78);
        chk("midrst_first_dp", {31'd0, dif.dp}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_4digit.md
Name: seg7_scan_4digit

Overview:
- Downstream consumer of the 500 Hz divided clock. Drives a 4-digit, common-anode, multiplexed 7-segment display from a 16-bit hex value.
- The 500 Hz signal is never used as a clock. It is synchronised into the clk_in (50 MHz) domain, and each rising edge becomes a one-cycle scan tick.
- Each tick advances the display to the next digit. A short all-off blanking gap is inserted between digits to prevent ghosting.

Parameters:
- BLANK_CYCLES, 64: clk_in cycles with all anodes off between digits. Legal range 1..255.

Ports:
- clk_in  input  1  50 MHz system clock.
- rst  input  1  Asynchronous, active-high reset.
- refresh_in  input  1  500 Hz square wave from the clock divider. Asynchronous to the scan logic's sampling.
- value  input  16  Hex value to display. value[3:0] is digit 0 (rightmost).
- dp_in  input  4  Decimal point request per digit. Bit n is digit n; 1 = lit.
- blank_lz  input  1  1 = suppress leading zeros.
- an  output  4  Anode enables, active-low. an[n] = digit n.
- seg  output  7  Segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  Decimal point, active-low.
- digit_idx  output  2  Index of the digit currently (or last) shown.

Behaviour:
- Reset (asynchronous): all outputs and internal state go to the values below.
  - an=4'b1111, seg=7'h7F, dp=1.
  - digit_idx=3, state=IDLE, sync flops=0, blank counter=0, shadow registers=0.
- Synchroniser and edge detect:
  - refresh_in passes through a 2-FF synchroniser plus one edge-detect flop.
  - tick=1 for exactly one clk_in cycle per rising edge.
  - tick fires in the 3rd clk_in rising edge after refresh_in rises (sampled at setup-safe points).
- State machine, states IDLE, BLANK, SHOW:
  - IDLE: display dark. On tick -> BLANK, counter=0.
  - SHOW: current digit lit. On tick -> BLANK, counter=0.
  - BLANK:
    - an=4'b1111 and seg=7'h7F for BLANK_CYCLES cycles; counter increments each cycle.
    - When counter==BLANK_CYCLES-1 -> SHOW, digit_idx <= digit_idx+1 (wraps 3->0).
  - Tick arriving while in BLANK is dropped: no queueing, no extension.
- Shadow latch (no tearing):
  - On the BLANK->SHOW transition into digit 0, value, dp_in and blank_lz are captured into shadow registers.
  - Digits 1..3 of that scan use the shadow copy.
  - Input changes mid-scan appear only at the next digit 0.
- Output timing:
  - an, seg, dp and digit_idx are registered.
  - The first cycle in SHOW already presents the new digit's outputs.
- SHOW outputs: an = one-hot-low of digit_idx (digit 0 -> 4'b1110, digit 3 -> 4'b0111).
- Hex decode of the shadow nibble (active-low {g..a}):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78.
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- Leading-zero suppression (shadow blank_lz=1):
  - Digit 3 is blanked if nibble3==0.
  - Digit 2 is blanked if nibbles 3..2 are all 0.
  - Digit 1 is blanked if nibbles 3..1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives seg=7'h7F, but its anode stays asserted and dp still follows the shadow dp bit.
- dp = ~shadow_dp[digit_idx] in SHOW; 1 otherwise.
- Scan timing: one digit per 500 Hz period, so a full scan takes 8 ms (125 Hz frame rate).
- Reset mid-operation: returns immediately to the reset state. Display stays dark until the next tick after reset release.

Test Plan:
- Reset: assert rst, hold refresh_in toggling -> an=4'b1111, seg=7'h7F, dp=1, digit_idx=3. No anode is ever asserted while rst=1.
- Scan order: value=16'h12AF, dp_in=4'b0100, blank_lz=0, four refresh edges (BLANK_CYCLES=64). Required sequence:
  - an=1110/seg=0E/dp=1
  - an=1101/seg=08/dp=1
  - an=1011/seg=24/dp=0
  - an=0111/seg=79/dp=1
  - Each digit is preceded by exactly 64 cycles of an=1111, and the SHOW entry comes 3+64 cycles after the refresh_in rise.
- Leading zeros: value=16'h0005, blank_lz=1 -> digits 3,2,1 show seg=7F with their anode low; digit 0 shows seg=12. With value=16'h0000, digit 0 shows seg=40.
- No tearing: change value from 16'h1111 to 16'h2222 while digit 2 is shown -> digit 3 still shows 79; the next digit 0 shows 24.
- Dropped tick: BLANK_CYCLES=64, inject a second refresh rise 20 cycles after the first -> single BLANK of 64 cycles; digit_idx advances by exactly 1.
- Reset mid-BLANK: assert rst 30 cycles into BLANK -> outputs go to reset values at once. After release, the first tick leads to a BLANK then digit 0 (an=1110).
